// File: rtl/hs_arb_pkg.sv
// Shared definitions for the send/ack round-robin arbiter.
// FSM state codes and counter sizing helper.
package hs_arb_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ACK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Width of the REQ wait counter; at least one bit when timeout is off.
    function automatic int cnt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/hs_arbiter_rr_picker.sv
// Round-robin winner selection, purely combinational.
// Searches upward from the slot after ptr, wrapping around.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    logic [PW-1:0] k;

    // First requester strictly after ptr (circular) wins.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = PW'((int'(ptr) + i) % N_REQ);
            if (!valid && req[k]) begin
                win[k] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_arbiter.sv
// Shares one send/ack peripheral port among N_REQ requesters,
// round-robin, with a REQ timeout and a completed-transfer count.
module hs_arbiter
    import hs_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  send_i,
    input  logic [N_REQ*DW-1:0] dados_i,
    output logic [N_REQ-1:0]  ack_o,
    output logic              send_o,
    output logic [DW-1:0]     dados_o,
    input  logic              ack_i,
    output logic [N_REQ-1:0]  grant_o,
    output logic [ST_W-1:0]   estado_o,
    output logic              err_o,
    output logic [7:0]        xfer_cnt_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = cnt_w(TIMEOUT);
    localparam int TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] WLIM = CW'(TL);

    state_t          st;
    logic [PW-1:0]   g;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   wcnt;
    logic [7:0]      xcnt;
    logic            aborted;

    logic [N_REQ-1:0] win;
    logic             win_v;
    logic [PW-1:0]    widx;
    logic [DW-1:0]    wdat;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req   (send_i),
        .ptr   (ptr),
        .win   (win),
        .valid (win_v)
    );

    // Encode the one-hot winner and select its data word.
    always_comb begin
        widx = '0;
        wdat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                widx = PW'(i);
                wdat = dados_i[i*DW +: DW];
            end
        end
    end

    // Arbiter FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_IDLE;
            g       <= '0;
            ptr     <= PW'(N_REQ - 1);
            wcnt    <= '0;
            xcnt    <= '0;
            aborted <= 1'b0;
            send_o  <= 1'b0;
            ack_o   <= '0;
            grant_o <= '0;
            dados_o <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (win_v) begin
                        st      <= ST_REQ;
                        g       <= widx;
                        wcnt    <= '0;
                        aborted <= 1'b0;
                        send_o  <= 1'b1;
                        grant_o <= win;
                        dados_o <= wdat;
                    end
                end
                ST_REQ: begin
                    if (ack_i) begin
                        st     <= ST_ACK;
                        send_o <= 1'b0;
                        ack_o  <= grant_o;
                    end else if (TIMEOUT != 0 && wcnt == WLIM) begin
                        st      <= ST_ERR;
                        aborted <= 1'b1;
                        send_o  <= 1'b0;
                        err_o   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!ack_i) begin
                        st    <= ST_DONE;
                        ack_o <= '0;
                    end
                end
                ST_DONE: begin
                    if (!send_i[g]) begin
                        st      <= ST_IDLE;
                        ptr     <= g;
                        grant_o <= '0;
                        dados_o <= '0;
                        if (!aborted) begin
                            xcnt <= xcnt + 8'd1;
                        end
                    end
                end
                ST_ERR: begin
                    st <= ST_DONE;
                end
                default: begin
                    st      <= ST_IDLE;
                    send_o  <= 1'b0;
                    ack_o   <= '0;
                    grant_o <= '0;
                    dados_o <= '0;
                end
            endcase
        end
    end

    assign estado_o   = st;
    assign xfer_cnt_o = xcnt;

endmodule
